// File: rtl/sample_iter.sv
// sample_iter: walks every grid sample inside a triangle's snapped bounding box in raster order.
// Holds one triangle at a time; halt_out stalls the upstream stage until the box is exhausted.
module sample_iter #(
  parameter int SIGFIG = 24,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [VERTS*AXIS*SIGFIG-1:0]   tri_in,
  input  logic [COLORS*SIGFIG-1:0]       color_in,
  input  logic [4*SIGFIG-1:0]            box_in,
  input  logic                           valid_in,
  output logic                           halt_out,
  input  logic [3:0]                     subsample,
  input  logic                           halt_in,
  output logic [VERTS*AXIS*SIGFIG-1:0]   tri_out,
  output logic [COLORS*SIGFIG-1:0]       color_out,
  output logic [2*SIGFIG-1:0]            sample_out,
  output logic                           valid_out
);

  typedef enum logic {WAIT, TEST} state_t;

  localparam logic signed [SIGFIG:0] ONE = 1;

  state_t                          state_q, state_d;
  logic [VERTS*AXIS*SIGFIG-1:0]    tri_q, tri_d;
  logic [COLORS*SIGFIG-1:0]        color_q, color_d;
  logic signed [SIGFIG-1:0]        x_q, x_d, y_q, y_d;
  logic signed [SIGFIG-1:0]        ll_x_q, ll_x_d, ur_x_q, ur_x_d, ur_y_q, ur_y_d;
  logic signed [SIGFIG-1:0]        in_ll_x, in_ll_y, in_ur_x, in_ur_y;
  logic signed [SIGFIG:0]          step, nx, ny;
  logic                            x_end, y_end;

  assign in_ll_x = box_in[SIGFIG-1:0];
  assign in_ll_y = box_in[2*SIGFIG-1:SIGFIG];
  assign in_ur_x = box_in[3*SIGFIG-1:2*SIGFIG];
  assign in_ur_y = box_in[4*SIGFIG-1:3*SIGFIG];

  // Sums carry one extra bit so a step past the top of the coordinate range cannot wrap.
  always_comb begin
    step = subsample[2] ? ONE << (RADIX - 1) :
           subsample[1] ? ONE << (RADIX - 2) :
           subsample[0] ? ONE << (RADIX - 3) : ONE << RADIX;
    nx = $signed({x_q[SIGFIG-1], x_q}) + step;
    ny = $signed({y_q[SIGFIG-1], y_q}) + step;
    x_end = nx > $signed({ur_x_q[SIGFIG-1], ur_x_q});
    y_end = ny > $signed({ur_y_q[SIGFIG-1], ur_y_q});
    state_d = state_q;
    tri_d = tri_q;
    color_d = color_q;
    x_d = x_q;
    y_d = y_q;
    ll_x_d = ll_x_q;
    ur_x_d = ur_x_q;
    ur_y_d = ur_y_q;
    if (state_q == WAIT) begin
      if (valid_in && in_ll_x <= in_ur_x && in_ll_y <= in_ur_y) begin
        state_d = TEST;
        tri_d = tri_in;
        color_d = color_in;
        x_d = in_ll_x;
        y_d = in_ll_y;
        ll_x_d = in_ll_x;
        ur_x_d = in_ur_x;
        ur_y_d = in_ur_y;
      end
    end else if (!halt_in) begin
      if (!x_end) x_d = nx[SIGFIG-1:0];
      else if (!y_end) begin
        x_d = ll_x_q;
        y_d = ny[SIGFIG-1:0];
      end else state_d = WAIT;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT;
      tri_q <= '0;
      color_q <= '0;
      x_q <= '0;
      y_q <= '0;
      ll_x_q <= '0;
      ur_x_q <= '0;
      ur_y_q <= '0;
    end else begin
      state_q <= state_d;
      tri_q <= tri_d;
      color_q <= color_d;
      x_q <= x_d;
      y_q <= y_d;
      ll_x_q <= ll_x_d;
      ur_x_q <= ur_x_d;
      ur_y_q <= ur_y_d;
    end
  end

  assign halt_out   = state_q == TEST;
  assign valid_out  = state_q == TEST;
  assign tri_out    = tri_q;
  assign color_out  = color_q;
  assign sample_out = {y_q, x_q};

endmodule

// File: tb/tb_sample_iter.sv
// tb_sample_iter: directed checks of raster order, stalls, degenerate/empty boxes and reset.
module tb_sample_iter;

  logic         clk = 0;
  logic         rst_n = 0;
  logic [215:0] tri_in = '0;
  logic [71:0]  color_in = '0;
  logic [95:0]  box_in = '0;
  logic         valid_in = 0;
  logic         halt_out;
  logic [3:0]   subsample = 4'b1000;
  logic         halt_in = 0;
  logic [215:0] tri_out;
  logic [71:0]  color_out;
  logic [47:0]  sample_out;
  logic         valid_out;

  logic [215:0] tri_a = {27{8'h3C}}, tri_b = {27{8'hC3}};
  logic [71:0]  color_a = {9{8'h5A}}, color_b = {9{8'hA5}};
  int pass_cnt = 0, total = 0;

  sample_iter dut (
    .clk(clk), .rst_n(rst_n), .tri_in(tri_in), .color_in(color_in), .box_in(box_in),
    .valid_in(valid_in), .halt_out(halt_out), .subsample(subsample), .halt_in(halt_in),
    .tri_out(tri_out), .color_out(color_out), .sample_out(sample_out), .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  function automatic logic [95:0] box(input int llx, input int lly, input int urx, input int ury);
    return {24'(ury), 24'(urx), 24'(lly), 24'(llx)};
  endfunction

  // Presents one triangle for a single accepting edge; returns at the negedge showing sample 0.
  task automatic send(input logic [95:0] b, input logic [3:0] ss);
    @(negedge clk);
    subsample = ss;
    box_in = b;
    tri_in = tri_a;
    color_in = color_a;
    valid_in = 1;
    @(negedge clk);
    valid_in = 0;
    tri_in = tri_b;
    color_in = color_b;
  endtask

  task automatic test_reset;
    #3;
    total++;
    if ({valid_out, halt_out} !== 2'b00) $display("FAIL reset_flags got=%b want=00", {valid_out, halt_out});
    else pass_cnt++;
    total++;
    if ({sample_out, tri_out, color_out} !== '0) $display("FAIL reset_regs got=%h want=0", sample_out);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_basic;
    int ex[4] = '{0, 1024, 0, 1024};
    int ey[4] = '{0, 0, 1024, 1024};
    send(box(0, 0, 1024, 1024), 4'b1000);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (!valid_out || !halt_out || sample_out !== {24'(ey[i]), 24'(ex[i])})
        $display("FAIL basic_s%0d got v=%b h=%b s=%h want s=%h", i, valid_out, halt_out, sample_out, {24'(ey[i]), 24'(ex[i])});
      else pass_cnt++;
      if (i == 3) begin
        total++;
        if (tri_out !== tri_a || color_out !== color_a) $display("FAIL basic_latch got tri=%h col=%h want col=%h", tri_out, color_out, color_a);
        else pass_cnt++;
      end
      @(negedge clk);
    end
    total++;
    if ({valid_out, halt_out} !== 2'b00) $display("FAIL basic_done got=%b want=00", {valid_out, halt_out});
    else pass_cnt++;
  endtask

  task automatic test_sub4;
    send(box(0, 0, 1024, 1024), 4'b0100);
    for (int i = 0; i < 9; i++) begin
      total++;
      if (!valid_out || sample_out !== {24'((i / 3) * 512), 24'((i % 3) * 512)})
        $display("FAIL sub4_s%0d got v=%b s=%h want s=%h", i, valid_out, sample_out, {24'((i / 3) * 512), 24'((i % 3) * 512)});
      else pass_cnt++;
      @(negedge clk);
    end
    total++;
    if (valid_out !== 1'b0) $display("FAIL sub4_done got=%b want=0", valid_out);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    @(negedge clk);
    subsample = 4'b1000;
    box_in = box(2048, 3072, 2048, 3072);
    tri_in = tri_a;
    valid_in = 1;
    @(negedge clk);
    total++;
    if (!valid_out || sample_out !== {24'(3072), 24'(2048)}) $display("FAIL b2b_first got v=%b s=%h want s=%h", valid_out, sample_out, {24'(3072), 24'(2048)});
    else pass_cnt++;
    box_in = box(-1024, 512, -1024, 512);
    tri_in = tri_b;
    @(negedge clk);
    total++;
    if ({valid_out, halt_out} !== 2'b00) $display("FAIL b2b_bubble got=%b want=00", {valid_out, halt_out});
    else pass_cnt++;
    @(negedge clk);
    valid_in = 0;
    total++;
    if (!valid_out || sample_out !== {24'(512), 24'(-1024)} || tri_out !== tri_b)
      $display("FAIL b2b_second got v=%b s=%h want s=%h", valid_out, sample_out, {24'(512), 24'(-1024)});
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (valid_out !== 1'b0) $display("FAIL b2b_single got=%b want=0", valid_out);
    else pass_cnt++;
  endtask

  task automatic test_inverted;
    send(box(1024, 0, 0, 0), 4'b1000);
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({valid_out, halt_out} !== 2'b00) $display("FAIL inverted_c%0d got=%b want=00", i, {valid_out, halt_out});
      else pass_cnt++;
      @(negedge clk);
    end
  endtask

  task automatic test_halt;
    int ex[7] = '{0, 1024, 1024, 1024, 1024, 0, 1024};
    int ey[7] = '{0, 0, 0, 0, 0, 1024, 1024};
    send(box(0, 0, 1024, 1024), 4'b1000);
    for (int i = 0; i < 7; i++) begin
      total++;
      if (!valid_out || sample_out !== {24'(ey[i]), 24'(ex[i])})
        $display("FAIL halt_s%0d got v=%b s=%h want s=%h", i, valid_out, sample_out, {24'(ey[i]), 24'(ex[i])});
      else pass_cnt++;
      halt_in = (i >= 1 && i <= 3);
      @(negedge clk);
    end
    total++;
    if (valid_out !== 1'b0) $display("FAIL halt_done got=%b want=0", valid_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    send(box(0, 0, 1024, 1024), 4'b0100);
    @(negedge clk);
    total++;
    if (sample_out !== {24'(0), 24'(512)}) $display("FAIL rstmid_s1 got=%h want=%h", sample_out, {24'(0), 24'(512)});
    else pass_cnt++;
    #2 rst_n = 0;
    #1;
    total++;
    if ({valid_out, halt_out} !== 2'b00 || sample_out !== '0) $display("FAIL rstmid_async got=%b s=%h want=00 s=0", {valid_out, halt_out}, sample_out);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++;
      if (valid_out !== 1'b0) $display("FAIL rstmid_idle%0d got=%b want=0", i, valid_out);
      else pass_cnt++;
    end
    rst_n = 0;
    box_in = box(4096, 1024, 4096, 1024);
    subsample = 4'b1000;
    valid_in = 1;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    valid_in = 0;
    total++;
    if (!valid_out || sample_out !== {24'(1024), 24'(4096)}) $display("FAIL first_edge got v=%b s=%h want s=%h", valid_out, sample_out, {24'(1024), 24'(4096)});
    else pass_cnt++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sub4();
    test_back_to_back();
    test_inverted();
    test_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
